// File: rtl/hex_dump_sequencer.sv
// Turns one data word into uppercase ASCII hex characters, MS nibble first,
// with an optional CR/LF trailer, over valid/ready handshakes on both sides.
module hex_dump_sequencer #(
    parameter int unsigned NBR_OF_NIBBLES = 4,
    parameter bit          APPEND_NEWLINE = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NBR_OF_NIBBLES*4-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [7:0]                  out_byte,
    output logic                        busy
);

    localparam int unsigned DATA_W = NBR_OF_NIBBLES * 4;
    localparam int unsigned CNT_W  = (NBR_OF_NIBBLES > 1) ? $clog2(NBR_OF_NIBBLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NBR_OF_NIBBLES - 1);
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIGIT = 2'd1,
        CR    = 2'd2,
        LF    = 2'd3
    } state_t;

    state_t             state;
    logic [DATA_W-1:0]  shift_reg;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  shift_next;
    logic [3:0]         next_nibble;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + 8'(nib);
        end
        return 8'h37 + 8'(nib);
    endfunction

    // Nibble that becomes visible after the current digit transfers.
    assign shift_next  = shift_reg << 4;
    assign next_nibble = shift_next[DATA_W-1 -: 4];

    // Reset must close the input immediately, so it gates the registered state.
    assign in_ready = (state == IDLE) && !reset;

    // out_byte/out_valid are loaded with the value for the upcoming state so
    // they never depend combinationally on out_ready or in_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_byte  <= 8'h00;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shift_reg <= in_data;
                        cnt       <= CNT_LOAD;
                        out_valid <= 1'b1;
                        out_byte  <= hex_ascii(in_data[DATA_W-1 -: 4]);
                        busy      <= 1'b1;
                        state     <= DIGIT;
                    end
                end
                DIGIT: begin
                    if (out_ready) begin
                        if (cnt != '0) begin
                            shift_reg <= shift_next;
                            cnt       <= cnt - CNT_W'(1);
                            out_byte  <= hex_ascii(next_nibble);
                        end else if (APPEND_NEWLINE) begin
                            out_byte  <= CHAR_CR;
                            state     <= CR;
                        end else begin
                            out_valid <= 1'b0;
                            out_byte  <= 8'h00;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                CR: begin
                    if (out_ready) begin
                        out_byte <= CHAR_LF;
                        state    <= LF;
                    end
                end
                LF: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_byte  <= 8'h00;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_dump_sequencer.sv
// Scoreboard bench: two instances (N=4 with CR/LF, N=1 without) against a
// word-to-characters reference model.
module tb_hex_dump_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
    logic [15:0] a_in_data;
    logic [7:0]  a_out_byte;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [3:0]  b_in_data;
    logic [7:0]  b_out_byte;

    hex_dump_sequencer #(.NBR_OF_NIBBLES(4), .APPEND_NEWLINE(1'b1)) dut_a (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_byte(a_out_byte),
        .busy(a_busy)
    );

    hex_dump_sequencer #(.NBR_OF_NIBBLES(1), .APPEND_NEWLINE(1'b0)) dut_b (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_byte(b_out_byte),
        .busy(b_busy)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] qa[$], qb[$], loga[$], logb[$];
    int  a_mode = 0, b_mode = 0, a_phase = 0, b_phase = 0;
    bit  a_churn = 0, b_churn = 0;
    bit  a_stall = 0, b_stall = 0;
    logic [7:0] a_stall_byte, b_stall_byte;
    int  b_acc = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] hex_char(input int v);
        return (v < 10) ? 8'(48 + v) : 8'(65 + v - 10);
    endfunction

    // Reference model: every nibble of the word, MS first, then optional CR LF.
    task automatic push_word(input logic [31:0] w, input int nibbles, input bit nl, inout logic [7:0] q[$]);
        for (int i = nibbles - 1; i >= 0; i--) q.push_back(hex_char(int'((w >> (4 * i)) & 32'hF)));
        if (nl) begin
            q.push_back(8'h0D);
            q.push_back(8'h0A);
        end
    endtask

    task automatic check_log(input string nm, input logic [7:0] got[$], input logic [7:0] exp[$]);
        check({nm, "_len"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            if (i < got.size()) check(nm, 32'(got[i]), 32'(exp[i]));
    endtask

    // Downstream ready generators and data churn, driven after the test thread.
    always @(posedge clk) begin
        #2;
        a_phase = (a_phase + 1) % 3;
        b_phase = (b_phase + 1) % 3;
        case (a_mode)
            0: a_out_ready = 1'b1;
            1: a_out_ready = (a_phase == 0);
            default: a_out_ready = 1'($urandom_range(0, 1));
        endcase
        case (b_mode)
            0: b_out_ready = 1'b1;
            1: b_out_ready = (b_phase == 0);
            default: b_out_ready = 1'($urandom_range(0, 1));
        endcase
        if (reset) begin
            a_out_ready = 1'b0;
            b_out_ready = 1'b0;
        end
        if (a_churn) a_in_data = 16'($urandom);
        if (b_churn) b_in_data = 4'($urandom);
    end

    // Monitor A: status vs. scoreboard occupancy, byte pops, accept pushes.
    always @(negedge clk) begin
        if (reset) begin
            check("a_in_ready_in_reset", 32'(a_in_ready), 32'd0);
            qa.delete();
            a_stall = 0;
        end else begin
            check("a_out_valid", 32'(a_out_valid), 32'(qa.size() != 0));
            check("a_busy", 32'(a_busy), 32'(qa.size() != 0));
            check("a_in_ready", 32'(a_in_ready), 32'(qa.size() == 0));
            if (a_stall) check("a_hold", 32'(a_out_byte), 32'(a_stall_byte));
            a_stall = 0;
            if (a_out_valid && qa.size() != 0) begin
                if (a_out_ready) begin
                    check("a_byte", 32'(a_out_byte), 32'(qa.pop_front()));
                    loga.push_back(a_out_byte);
                end else begin
                    a_stall = 1;
                    a_stall_byte = a_out_byte;
                end
            end
            if (a_in_valid && a_in_ready) push_word(32'(a_in_data), 4, 1'b1, qa);
        end
    end

    // Monitor B: same checks for the single-nibble, no-newline instance.
    always @(negedge clk) begin
        if (reset) begin
            check("b_in_ready_in_reset", 32'(b_in_ready), 32'd0);
            qb.delete();
            b_stall = 0;
        end else begin
            check("b_out_valid", 32'(b_out_valid), 32'(qb.size() != 0));
            check("b_busy", 32'(b_busy), 32'(qb.size() != 0));
            check("b_in_ready", 32'(b_in_ready), 32'(qb.size() == 0));
            if (b_stall) check("b_hold", 32'(b_out_byte), 32'(b_stall_byte));
            b_stall = 0;
            if (b_out_valid && qb.size() != 0) begin
                if (b_out_ready) begin
                    check("b_byte", 32'(b_out_byte), 32'(qb.pop_front()));
                    logb.push_back(b_out_byte);
                end else begin
                    b_stall = 1;
                    b_stall_byte = b_out_byte;
                end
            end
            if (b_in_valid && b_in_ready) begin
                push_word(32'(b_in_data), 1, 1'b0, qb);
                b_acc++;
            end
        end
    end

    task automatic send_a(input logic [15:0] w);
        bit ok = 0;
        @(posedge clk); #1;
        a_in_valid = 1'b1;
        a_in_data  = w;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (a_in_ready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        a_in_data  = 16'($urandom);
        check("a_accept_timeout", 32'(ok), 32'd1);
    endtask

    task automatic send_b(input logic [3:0] w);
        bit ok = 0;
        @(posedge clk); #1;
        b_in_valid = 1'b1;
        b_in_data  = w;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (b_in_ready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        b_in_data  = 4'($urandom);
        check("b_accept_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle_a();
        bit ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (qa.size() == 0 && a_in_ready === 1'b1) begin ok = 1; break; end
        end
        check("a_idle_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle_b();
        bit ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (qb.size() == 0 && b_in_ready === 1'b1) begin ok = 1; break; end
        end
        check("b_idle_timeout", 32'(ok), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] exp[$];
        int acc0;
        bit seen;

        reset = 1'b1;
        a_in_valid = 1'b0; a_in_data = 16'h0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = 4'h0;  b_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("a_out_byte_reset", 32'(a_out_byte), 32'h00);
        check("b_out_byte_reset", 32'(b_out_byte), 32'h00);

        // Basic dump
        a_mode = 0;
        loga.delete();
        send_a(16'h1A3F);
        wait_idle_a();
        exp = '{8'h31, 8'h41, 8'h33, 8'h46, 8'h0D, 8'h0A};
        check_log("a_basic", loga, exp);

        // Digit boundaries
        loga.delete();
        send_a(16'h0009); send_a(16'h00A0); send_a(16'h00FF); send_a(16'h9AF0);
        wait_idle_a();
        exp = '{8'h30, 8'h30, 8'h30, 8'h39, 8'h0D, 8'h0A,
                8'h30, 8'h30, 8'h41, 8'h30, 8'h0D, 8'h0A,
                8'h30, 8'h30, 8'h46, 8'h46, 8'h0D, 8'h0A,
                8'h39, 8'h41, 8'h46, 8'h30, 8'h0D, 8'h0A};
        check_log("a_digits", loga, exp);

        // Backpressure with in_data scrambled after the accept
        a_mode = 1;
        loga.delete();
        send_a(16'hBEEF);
        wait_idle_a();
        exp = '{8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
        check_log("a_backpressure", loga, exp);

        // Reset mid-word after "1","2"
        a_mode = 0;
        loga.delete();
        send_a(16'h1234);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (loga.size() >= 2) begin seen = 1; break; end
        end
        check("a_two_digits_timeout", 32'(seen), 32'd1);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("a_out_byte_after_reset", 32'(a_out_byte), 32'h00);
        loga.delete();
        send_a(16'h0000);
        wait_idle_a();
        exp = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};
        check_log("a_after_reset", loga, exp);

        // in_valid held with changing data throughout dumps
        a_mode = 2;
        @(posedge clk); #1;
        a_churn = 1;
        a_in_valid = 1'b1;
        repeat (300) @(posedge clk);
        #1 a_in_valid = 1'b0;
        a_churn = 0;
        wait_idle_a();

        // Random words with random backpressure
        for (int i = 0; i < 40; i++) send_a(16'($urandom));
        wait_idle_a();

        // Single nibble, no newline
        b_mode = 0;
        logb.delete();
        send_b(4'hC);
        wait_idle_b();
        exp = '{8'h43};
        check_log("b_single", logb, exp);

        // Back-to-back: one accept every two cycles
        @(posedge clk); #1;
        b_churn = 1;
        b_in_valid = 1'b1;
        acc0 = b_acc;
        repeat (40) @(negedge clk);
        #1 check("b_throughput", 32'(b_acc - acc0), 32'd20);
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        b_churn = 0;
        wait_idle_b();

        // Random backpressure with held in_valid
        b_mode = 2;
        @(posedge clk); #1;
        b_churn = 1;
        b_in_valid = 1'b1;
        repeat (200) @(posedge clk);
        #1 b_in_valid = 1'b0;
        b_churn = 0;
        wait_idle_b();
        b_mode = 1;
        for (int i = 0; i < 16; i++) send_b(4'(i));
        wait_idle_b();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
